// File: rtl/tarea3_pkg.sv
// Shared types and constants for the result serializer.
package tarea3_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO,
    GAP,
    DONE
  } ser_state_t;

  // A field of width $clog2(v) collapses to zero bits when v <= 1, so keep at least one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Loadable down-counter that times the idle gap between UART bytes.
module byte_gap_timer
  import tarea3_pkg::*;
#(
  parameter int DELAY = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic zero
);

  localparam int TW = clog2_min1(DELAY + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Load takes priority; counting stops at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = TW'(DELAY);
    else if (count && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_result_serializer.sv
// Captures up to NUM_WORDS result words and streams them MSB-byte-first into
// the UART transmitter using its tx_start/tx_busy handshake.
module piso_result_serializer
  import tarea3_pkg::*;
#(
  parameter  int NUM_WORDS        = 8,
  parameter  int WORD_WIDTH       = 32,
  parameter  int INTER_BYTE_DELAY = 1000,
  localparam int CW               = $clog2(NUM_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  begin_transmission,
  input  logic [CW-1:0]         word_count,
  input  logic [WORD_WIDTH-1:0] data_in [NUM_WORDS],
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  tx_sent,
  output logic                  busy
);

  localparam int BPW = WORD_WIDTH / BYTE_W;
  localparam int BW  = clog2_min1(BPW);
  localparam int WW  = clog2_min1(NUM_WORDS);

  ser_state_t              state_q, state_d;
  logic                    tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]       tx_data_q, tx_data_d;
  logic                    tx_sent_q, tx_sent_d;
  logic                    busy_q, busy_d;
  logic [BW-1:0]           byte_q, byte_d;
  logic [WW-1:0]           word_q, word_d;
  logic [CW-1:0]           n_q, n_d;
  logic [WORD_WIDTH-1:0]   data_q [NUM_WORDS];

  logic                    capture;
  logic                    tmr_load, tmr_count, tmr_zero;
  logic [CW-1:0]           n_clamp;
  logic [WORD_WIDTH-1:0]   cur_word;
  logic [BYTE_W-1:0]       cur_byte;
  logic                    last_byte;

  assign n_clamp   = (word_count > CW'(NUM_WORDS)) ? CW'(NUM_WORDS) : word_count;
  assign cur_word  = data_q[word_q];
  assign cur_byte  = cur_word[(BPW - 1 - int'(byte_q)) * BYTE_W +: BYTE_W];
  assign last_byte = (CW'(word_q) == n_q - CW'(1)) && (byte_q == BW'(BPW - 1));

  byte_gap_timer #(
    .DELAY (INTER_BYTE_DELAY)
  ) u_gap (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .count (tmr_count),
    .zero  (tmr_zero)
  );

  // Next-state and next-output logic. The first byte is launched straight
  // from IDLE (using data_in) so tx_start follows the begin pulse by one cycle.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_sent_d  = 1'b0;
    busy_d     = busy_q;
    byte_d     = byte_q;
    word_d     = word_q;
    n_d        = n_q;
    capture    = 1'b0;
    tmr_load   = 1'b0;
    tmr_count  = 1'b0;
    case (state_q)
      IDLE: begin
        if (begin_transmission) begin
          capture = 1'b1;
          busy_d  = 1'b1;
          n_d     = n_clamp;
          byte_d  = '0;
          word_d  = '0;
          if (n_clamp == '0) begin
            tx_sent_d = 1'b1;
            state_d   = DONE;
          end else if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = data_in[0][WORD_WIDTH-1 -: BYTE_W];
            state_d    = WAIT_HI;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!tx_busy) begin
          tmr_load = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        tmr_count = 1'b1;
        if (tmr_zero) begin
          if (last_byte) begin
            tx_sent_d = 1'b1;
            state_d   = DONE;
          end else begin
            if (byte_q == BW'(BPW - 1)) begin
              byte_d = '0;
              word_d = word_q + 1'b1;
            end else begin
              byte_d = byte_q + 1'b1;
            end
            state_d = START;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_sent_q  <= 1'b0;
      busy_q     <= 1'b0;
      byte_q     <= '0;
      word_q     <= '0;
      n_q        <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tx_sent_q  <= tx_sent_d;
      busy_q     <= busy_d;
      byte_q     <= byte_d;
      word_q     <= word_d;
      n_q        <= n_d;
    end
  end

  // Shift buffer: snapshot of the frame taken on the accepted begin pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) data_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_WORDS; i++) data_q[i] <= data_in[i];
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign tx_sent  = tx_sent_q;
  assign busy     = busy_q;

endmodule
